// File: rtl/pic_bounce_ctrl_pkg.sv
// Shared types and helpers for the bouncing picture-overlay position scheduler.
package pic_bounce_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStepX,
    StStepY,
    StCommit
  } state_e;

  // Largest legal origin on an axis so the picture stays fully on screen.
  function automatic int unsigned axis_max(input int unsigned act, input int unsigned pic);
    return act - pic;
  endfunction

  function automatic int unsigned axis_centre(input int unsigned act, input int unsigned pic);
    return (act - pic) / 2;
  endfunction

endpackage

// File: rtl/pic_bounce_ctrl_axis_step.sv
// One axis move: next position, direction and bounce flag from position, step, direction and limit.
module pic_bounce_ctrl_axis_step #(
  parameter int unsigned W         = 13,
  parameter int unsigned STEP_BITS = 4
) (
  input  logic [W-1:0]         p,
  input  logic [STEP_BITS-1:0] d,
  input  logic                 dir,
  input  logic [W-1:0]         p_max,
  output logic [W-1:0]         p_next,
  output logic                 dir_next,
  output logic                 bounce
);

  logic [W-1:0] d_ext;
  logic [W-1:0] sum;

  assign d_ext = W'(d);
  assign sum   = p + d_ext;

  // dir = 1 means moving towards p_max; a zero step leaves the axis untouched.
  always_comb begin
    p_next   = p;
    dir_next = dir;
    bounce   = 1'b0;
    if (d != '0) begin
      if (dir) begin
        if (sum >= p_max) begin
          p_next   = p_max;
          dir_next = 1'b0;
          bounce   = 1'b1;
        end else begin
          p_next = sum;
        end
      end else begin
        if (p <= d_ext) begin
          p_next   = '0;
          dir_next = 1'b1;
          bounce   = 1'b1;
        end else begin
          p_next = p - d_ext;
        end
      end
    end
  end

endmodule

// File: rtl/pic_bounce_ctrl.sv
// Per-frame picture origin scheduler: moves and bounces the overlay once per vsync,
// with a valid/ready port for placing, pacing or freezing it.
module pic_bounce_ctrl
  import pic_bounce_ctrl_pkg::*;
#(
  parameter int unsigned X_BITS     = 12,
  parameter int unsigned Y_BITS     = 12,
  parameter int unsigned H_ACT      = 1280,
  parameter int unsigned V_ACT      = 720,
  parameter int unsigned PIC_WIDTH  = 256,
  parameter int unsigned PIC_HEIGHT = 256,
  parameter int unsigned STEP_BITS  = 4,
  parameter int unsigned DIV_BITS   = 8,
  parameter logic        VS_POL     = 1'b1
) (
  input  logic                 pix_clk,
  input  logic                 rst,
  input  logic                 vs_in,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [X_BITS-1:0]    cfg_x,
  input  logic [Y_BITS-1:0]    cfg_y,
  input  logic [STEP_BITS-1:0] cfg_dx,
  input  logic [STEP_BITS-1:0] cfg_dy,
  input  logic [DIV_BITS-1:0]  cfg_div,
  output logic [X_BITS-1:0]    pic_x_start,
  output logic [Y_BITS-1:0]    pic_y_start,
  output logic                 frame_tick,
  output logic                 bounce_x,
  output logic                 bounce_y
);

  localparam int unsigned W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 1;

  localparam logic [X_BITS-1:0] XMax    = X_BITS'(axis_max(H_ACT, PIC_WIDTH));
  localparam logic [Y_BITS-1:0] YMax    = Y_BITS'(axis_max(V_ACT, PIC_HEIGHT));
  localparam logic [X_BITS-1:0] XCentre = X_BITS'(axis_centre(H_ACT, PIC_WIDTH));
  localparam logic [Y_BITS-1:0] YCentre = Y_BITS'(axis_centre(V_ACT, PIC_HEIGHT));

  state_e state_q, state_d;

  logic                 vs_q;
  logic                 frame_edge;
  logic                 cfg_ready_q;
  logic                 cfg_accept;

  logic [X_BITS-1:0]    x_q;
  logic [Y_BITS-1:0]    y_q;
  logic                 dir_x_q, dir_y_q;
  logic [STEP_BITS-1:0] dx_q, dy_q;
  logic [DIV_BITS-1:0]  div_q, cnt_q;

  logic [X_BITS-1:0]    sh_x_q;
  logic [Y_BITS-1:0]    sh_y_q;
  logic                 sh_dir_x_q, sh_dir_y_q;
  logic                 sh_bx_q, sh_by_q;

  logic                 pend_q;
  logic [X_BITS-1:0]    pend_x_q;
  logic [Y_BITS-1:0]    pend_y_q;
  logic [STEP_BITS-1:0] pend_dx_q, pend_dy_q;
  logic [DIV_BITS-1:0]  pend_div_q;

  logic                 frame_tick_q, bounce_x_q, bounce_y_q;

  logic [W-1:0]         ax_p, ax_max, ax_p_next;
  logic [STEP_BITS-1:0] ax_d;
  logic                 ax_dir, ax_dir_next, ax_bounce;

  assign frame_edge = (vs_in == VS_POL) && (vs_q != VS_POL);
  // The ready flop covers IDLE; gating with the live edge makes a same-cycle edge win.
  assign cfg_ready  = cfg_ready_q & ~frame_edge;
  assign cfg_accept = cfg_valid & cfg_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (frame_edge) state_d = StStepX;
      StStepX:  state_d = StStepY;
      StStepY:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The single axis unit serves y during STEP_Y and x otherwise.
  always_comb begin
    ax_p   = W'(x_q);
    ax_d   = dx_q;
    ax_dir = dir_x_q;
    ax_max = W'(XMax);
    if (state_q == StStepY) begin
      ax_p   = W'(y_q);
      ax_d   = dy_q;
      ax_dir = dir_y_q;
      ax_max = W'(YMax);
    end
  end

  pic_bounce_ctrl_axis_step #(
    .W         (W),
    .STEP_BITS (STEP_BITS)
  ) u_axis_step (
    .p        (ax_p),
    .d        (ax_d),
    .dir      (ax_dir),
    .p_max    (ax_max),
    .p_next   (ax_p_next),
    .dir_next (ax_dir_next),
    .bounce   (ax_bounce)
  );

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vs_q         <= VS_POL;
      cfg_ready_q  <= 1'b0;
      x_q          <= XCentre;
      y_q          <= YCentre;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      dx_q         <= STEP_BITS'(1);
      dy_q         <= STEP_BITS'(1);
      div_q        <= '0;
      cnt_q        <= '0;
      sh_x_q       <= '0;
      sh_y_q       <= '0;
      sh_dir_x_q   <= 1'b1;
      sh_dir_y_q   <= 1'b1;
      sh_bx_q      <= 1'b0;
      sh_by_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_dx_q    <= '0;
      pend_dy_q    <= '0;
      pend_div_q   <= '0;
      frame_tick_q <= 1'b0;
      bounce_x_q   <= 1'b0;
      bounce_y_q   <= 1'b0;
    end else begin
      vs_q         <= vs_in;
      cfg_ready_q  <= (state_d == StIdle);
      frame_tick_q <= (state_q == StCommit);
      bounce_x_q   <= 1'b0;
      bounce_y_q   <= 1'b0;

      if (cfg_accept) begin
        pend_q     <= 1'b1;
        pend_x_q   <= (cfg_x > XMax) ? XMax : cfg_x;
        pend_y_q   <= (cfg_y > YMax) ? YMax : cfg_y;
        pend_dx_q  <= cfg_dx;
        pend_dy_q  <= cfg_dy;
        pend_div_q <= cfg_div;
      end

      case (state_q)
        StStepX: begin
          sh_x_q     <= X_BITS'(ax_p_next);
          sh_dir_x_q <= ax_dir_next;
          sh_bx_q    <= ax_bounce;
        end
        StStepY: begin
          sh_y_q     <= Y_BITS'(ax_p_next);
          sh_dir_y_q <= ax_dir_next;
          sh_by_q    <= ax_bounce;
        end
        StCommit: begin
          if (pend_q) begin
            x_q     <= pend_x_q;
            y_q     <= pend_y_q;
            dx_q    <= pend_dx_q;
            dy_q    <= pend_dy_q;
            div_q   <= pend_div_q;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end else if (enable && (cnt_q == div_q)) begin
            x_q        <= sh_x_q;
            y_q        <= sh_y_q;
            dir_x_q    <= sh_dir_x_q;
            dir_y_q    <= sh_dir_y_q;
            bounce_x_q <= sh_bx_q;
            bounce_y_q <= sh_by_q;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pic_x_start = x_q;
  assign pic_y_start = y_q;
  assign frame_tick  = frame_tick_q;
  assign bounce_x    = bounce_x_q;
  assign bounce_y    = bounce_y_q;

endmodule
